// File: rtl/c64_uart_pkg.sv
// c64_uart_pkg: shared types and constants for the C64 UART transmit path.
//   uart_parity_t   - decoded parity mode (NONE, EVEN, ODD)
//   uart_tx_state_t - transmitter FSM states
//   UART_MIN_DIV    - smallest effective baud divider
//   to_parity()     - maps the 2-bit cfg_parity field onto uart_parity_t
package c64_uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } uart_parity_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_MIN_DIV = 3;

    // 2'b11 is an unused encoding and behaves as no parity.
    function automatic uart_parity_t to_parity(input logic [1:0] c);
        return c == 2'b01 ? EVEN : c == 2'b10 ? ODD : NONE;
    endfunction

endpackage

// File: rtl/c64_uart_fifo.sv
// c64_uart_fifo: synchronous FIFO with wrap-bit pointers.
//   clk_sys, reset_n - clock, async active-low reset (pointers only)
//   push, din        - write side; pushes while full are ignored
//   pop, dout        - read side; dout shows the head entry
//   full, empty      - status derived from the pointers
//   level            - number of stored entries
module c64_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wp, rp;
    logic [W-1:0] mem [DEPTH];

    // Full when the indices match but the wrap bits differ.
    assign full  = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign empty = wp == rp;
    assign level = wp - rp;
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + 1'b1;
            if (pop && !empty)
                rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push && !full)
            mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/c64_uart_tx.sv
// c64_uart_tx: FIFO-buffered 8-bit UART transmitter, LSB first.
//   clk_sys, reset_n      - system clock, async active-low reset
//   baud_div              - bit period is baud_div+1 cycles (clamped to >= 3)
//   cfg_parity, cfg_stop2 - parity mode and two-stop-bit select
//   wr_data, wr_valid     - byte write; accepted when wr_ready
//   wr_ready              - FIFO not full
//   uart_tx               - registered serial line, idle high
//   busy                  - frame in progress or FIFO non-empty
//   fifo_level            - number of queued bytes
module c64_uart_tx
    import c64_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t   state, state_d;
    uart_parity_t     par_q;
    logic [DIV_W-1:0] timer, timer_d, div_q, div_eff;
    logic [7:0]       sh, sh_d, head;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [LW-1:0]    level_d;
    logic             stop_cnt, stop_cnt_d, stop2_q, par_bit;
    logic             tx_d, busy_d, push, pop, full, empty, bit_end;

    assign div_eff  = baud_div < DIV_W'(UART_MIN_DIV) ? DIV_W'(UART_MIN_DIV) : baud_div;
    assign push     = wr_valid && !full;
    assign wr_ready = !full;
    assign bit_end  = timer == '0;
    assign level_d  = fifo_level + LW'(push) - LW'(pop);

    c64_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (push),
        .din     (wr_data),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // uart_tx and busy are computed one cycle ahead so both leave flops.
    always_comb begin
        state_d    = state;
        sh_d       = sh;
        bit_idx_d  = bit_idx;
        stop_cnt_d = stop_cnt;
        tx_d       = uart_tx;
        pop        = 1'b0;
        unique case (state)
            IDLE:   pop = !empty;
            START:  if (bit_end) begin
                        state_d   = DATA;
                        tx_d      = sh[0];
                        bit_idx_d = 3'd0;
                    end
            DATA:   if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state_d    = par_q == NONE ? STOP : PARITY;
                            tx_d       = par_q == NONE ? 1'b1 : par_bit;
                            stop_cnt_d = stop2_q;
                        end else begin
                            sh_d      = sh >> 1;
                            tx_d      = sh[1];
                            bit_idx_d = bit_idx + 3'd1;
                        end
                    end
            PARITY: if (bit_end) begin
                        state_d    = STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = stop2_q;
                    end
            STOP:   if (bit_end) begin
                        if (stop_cnt)
                            stop_cnt_d = 1'b0;
                        else if (!empty)
                            pop = 1'b1;
                        else
                            state_d = IDLE;
                    end
        endcase
        // A pop (from IDLE or the last stop cycle) always starts a new frame.
        if (pop) begin
            state_d = START;
            tx_d    = 1'b0;
            sh_d    = head;
        end
        timer_d = pop ? div_eff : bit_end ? div_q : timer - 1'b1;
        busy_d  = state_d != IDLE || level_d != '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            timer    <= '0;
            sh       <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            div_q    <= DIV_W'(UART_MIN_DIV);
            par_q    <= NONE;
            stop2_q  <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            sh       <= sh_d;
            bit_idx  <= bit_idx_d;
            stop_cnt <= stop_cnt_d;
            uart_tx  <= tx_d;
            busy     <= busy_d;
            // Frame configuration is frozen at the pop that starts the frame.
            if (pop) begin
                div_q   <= div_eff;
                par_q   <= to_parity(cfg_parity);
                stop2_q <= cfg_stop2;
                par_bit <= ^head ^ (cfg_parity == 2'b10);
            end
        end
    end

endmodule

// File: tb/tb_c64_uart_tx.sv
module tb_c64_uart_tx;

    typedef struct {
        logic [7:0] d;
        logic [1:0] par;
        logic       stop2;
        int         period;
    } frame_t;

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  par;
        logic        stop2;
        logic [15:0] div;
        int          exp_len;
        logic        exp_par;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready, uart_tx, busy;
    logic [4:0]  fifo_level;

    frame_t sb[$];
    int     vectors = 0;
    int     miscompares = 0;
    logic   in_frame = 1'b0;
    logic   last_par = 1'b0;

    c64_uart_tx #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .baud_div   (baud_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int period_of(input logic [15:0] d);
        return (d < 16'd3 ? 3 : int'(d)) + 1;
    endfunction

    // Present one byte for one cycle; wr_valid stays high for back-to-back use.
    task automatic drive(input logic [7:0] d, input int per, output logic acc);
        frame_t f;
        wr_data  = d;
        wr_valid = 1'b1;
        acc      = wr_ready;
        @(posedge clk_sys);
        #1;
        if (acc) begin
            f = '{d, cfg_parity, cfg_stop2, per};
            sb.push_back(f);
        end
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((sb.size() != 0 || in_frame || busy) && n < lim) begin
            @(negedge clk_sys);
            n++;
        end
        chk("drain", n < lim, 1);
        @(posedge clk_sys);
        #1;
    endtask

    // Line monitor: every start bit pops the next expected frame and each bit
    // must hold its value for exactly one bit period.
    initial begin : monitor
        frame_t e;
        logic   b [12];
        int     nb, pp, guard;
        logic   ok, ab;
        forever begin
            @(negedge clk_sys);
            if (reset_n && uart_tx === 1'b0) begin
                in_frame = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_start", 0, 1);
                    guard = 0;
                    while (uart_tx === 1'b0 && reset_n && guard < 100) begin
                        @(negedge clk_sys);
                        guard++;
                    end
                end else begin
                    e = sb.pop_front();
                    b[0] = 1'b0;
                    for (int i = 0; i < 8; i++)
                        b[1+i] = e.d[i];
                    nb = 9;
                    pp = -1;
                    if (e.par == 2'b01 || e.par == 2'b10) begin
                        b[nb] = ^e.d ^ (e.par == 2'b10);
                        pp = nb;
                        nb++;
                    end
                    b[nb] = 1'b1;
                    nb++;
                    if (e.stop2) begin
                        b[nb] = 1'b1;
                        nb++;
                    end
                    ab = 1'b0;
                    for (int k = 0; k < nb; k++) begin
                        ok = 1'b1;
                        for (int c = 0; c < e.period; c++) begin
                            if (k != 0 || c != 0)
                                @(negedge clk_sys);
                            if (!reset_n)
                                ab = 1'b1;
                            else if (uart_tx !== b[k])
                                ok = 1'b0;
                            if (ab)
                                break;
                        end
                        if (ab)
                            break;
                        if (k == pp)
                            last_par = uart_tx;
                        chk($sformatf("frame_%02h_bit%0d", e.d, k), ok, 1);
                    end
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        vec_t v[7];
        logic acc, bz;
        int   len, accs, maxl;

        v[0] = '{8'hA5, 2'b00, 1'b0, 16'd3, 40, 1'b0};
        v[1] = '{8'hA5, 2'b01, 1'b0, 16'd3, 44, 1'b0};
        v[2] = '{8'hA5, 2'b10, 1'b0, 16'd3, 44, 1'b1};
        v[3] = '{8'h07, 2'b01, 1'b0, 16'd3, 44, 1'b1};
        v[4] = '{8'h3C, 2'b11, 1'b1, 16'd0, 44, 1'b0};
        v[5] = '{8'h07, 2'b10, 1'b1, 16'd5, 72, 1'b0};
        v[6] = '{8'hFF, 2'b00, 1'b0, 16'd1, 40, 1'b0};

        #2 reset_n = 1'b0;
        #1;
        chk("rst_tx", uart_tx, 1);
        chk("rst_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;

        foreach (v[i]) begin
            baud_div   = v[i].div;
            cfg_parity = v[i].par;
            cfg_stop2  = v[i].stop2;
            drive(v[i].d, period_of(v[i].div), acc);
            wr_valid = 1'b0;
            @(negedge clk_sys);
            chk("busy_rise", busy, 1);
            chk("level_one", fifo_level, 1);
            chk("idle_high", uart_tx, 1);
            @(negedge clk_sys);
            chk("start_low", uart_tx, 0);
            len = 1;
            while (busy && len < 1000) begin
                @(negedge clk_sys);
                if (busy)
                    len++;
            end
            chk("frame_len", len, v[i].exp_len);
            if (v[i].par == 2'b01 || v[i].par == 2'b10)
                chk("parity_bit", last_par, v[i].exp_par);
            chk("sb_empty", sb.size(), 0);
            @(posedge clk_sys);
            #1;
        end

        baud_div   = 16'd3;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b1;
        drive(8'h00, 4, acc);
        drive(8'hFF, 4, acc);
        wr_valid = 1'b0;
        @(negedge clk_sys);
        chk("b2b_first_start", uart_tx, 0);
        bz = 1'b1;
        repeat (43) begin
            @(negedge clk_sys);
            bz &= busy;
        end
        chk("b2b_last_stop", uart_tx, 1);
        @(negedge clk_sys);
        chk("b2b_second_start", uart_tx, 0);
        chk("b2b_busy", bz, 1);
        drain(1000);
        cfg_stop2 = 1'b0;

        drive(8'h5A, 4, acc);
        drive(8'hC3, 8, acc);
        wr_valid = 1'b0;
        repeat (10) @(negedge clk_sys);
        baud_div = 16'd7;
        drain(1000);
        baud_div = 16'd3;

        accs = 0;
        maxl = 0;
        for (int k = 0; k < 18; k++) begin
            drive(8'(k * 13 + 1), 4, acc);
            accs += int'(acc);
            if (int'(fifo_level) > maxl)
                maxl = int'(fifo_level);
        end
        chk("full_drop", acc, 0);
        wr_valid = 1'b0;
        chk("accepted", accs, 17);
        chk("ready_full", wr_ready, 0);
        chk("level_full", fifo_level, 16);
        drain(2000);
        chk("max_level", maxl, 16);

        drive(8'h96, 4, acc);
        drive(8'h69, 4, acc);
        wr_valid = 1'b0;
        repeat (8) @(posedge clk_sys);
        #1;
        chk("pre_reset_level", fifo_level, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_tx", uart_tx, 1);
        chk("async_rst_level", fifo_level, 0);
        chk("async_rst_busy", busy, 0);
        sb.delete();
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        drive(8'h3C, 4, acc);
        wr_valid = 1'b0;
        drain(1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
